ram_bist_ctrl: RTL and testbench

//  Parametrised write-then-verify controller wrapping an inferred single-port block RAM (DEPTH x DATA_W).
//  On start it fills every address from a selectable data pattern, reads everything back, compares

---
 rtl/ram_bist_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write-then-verify self-test controller around an inferred
// single-port block RAM. Fills every word from a selectable pattern, reads
// it all back, and reports pass/fail, mismatch count and first failing address.
module ram_bist_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 100,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [1:0]        inj,
  input  logic [ADDR_W-1:0] inj_addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] data_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};
  localparam logic              DRAIN_END = 1'(RD_LAT - 1);

  // Pattern word for address a; all arithmetic wraps at DATA_W bits.
  function automatic logic [DATA_W-1:0] expected_word(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] s,
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] a_ext;
    a_ext = DATA_W'(a);
    case (m)
      2'd0:    return s + a_ext;
      2'd1:    return s;
      2'd2:    return a[0] ? ~s : s;
      default: return s ^ a_ext;
    endcase
  endfunction

  // Fault injection flips bit 0; inj==3 is treated as no injection.
  function automatic logic inject_flag(
    input logic [1:0]        ij,
    input logic [ADDR_W-1:0] ia,
    input logic [ADDR_W-1:0] a
  );
    return (ij == 2'd2) || ((ij == 2'd1) && (a == ia));
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drain_q, drain_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [1:0]        inj_q, inj_d;
  logic [ADDR_W-1:0] inj_addr_q, inj_addr_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;
  logic              pass_q, pass_d;

  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] wr_data;

  logic              vld_p1_q;
  logic [ADDR_W-1:0] addr_p1_q;
  logic [DATA_W-1:0] dout_p1_q;

  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic              mismatch;

  logic [DATA_W-1:0] mem [DEPTH];

  assign wr_data = expected_word(mode_q, seed_q, addr_q)
                 ^ {{(DATA_W-1){1'b0}}, inject_flag(inj_q, inj_addr_q, addr_q)};

  // RAM write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_q] <= wr_data;
  end

  // Registered RAM read plus the address/valid that travel with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      addr_p1_q <= '0;
      dout_p1_q <= '0;
    end else begin
      vld_p1_q  <= rd_en;
      addr_p1_q <= addr_q;
      if (rd_en) dout_p1_q <= mem[addr_q];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              vld_p2_q;
      logic [ADDR_W-1:0] addr_p2_q;
      logic [DATA_W-1:0] dout_p2_q;

      // Optional RAM output register stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p2_q  <= 1'b0;
          addr_p2_q <= '0;
          dout_p2_q <= '0;
        end else begin
          vld_p2_q  <= vld_p1_q;
          addr_p2_q <= addr_p1_q;
          dout_p2_q <= dout_p1_q;
        end
      end

      assign cmp_vld  = vld_p2_q;
      assign cmp_addr = addr_p2_q;
      assign data_out = dout_p2_q;
    end else begin : g_lat1
      assign cmp_vld  = vld_p1_q;
      assign cmp_addr = addr_p1_q;
      assign data_out = dout_p1_q;
    end
  endgenerate

  assign mismatch = cmp_vld && (data_out != expected_word(mode_q, seed_q, cmp_addr));

  // Sequencer: next state, address walk, configuration latch and error tally
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    drain_d     = drain_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    inj_d       = inj_q;
    inj_addr_d  = inj_addr_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;

    if (mismatch) begin
      if (err_cnt_q == '0) first_err_d = cmp_addr;
      if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d      = mode;
          seed_d      = seed;
          inj_d       = inj;
          inj_addr_d  = inj_addr;
          err_cnt_d   = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
          addr_d      = '0;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_READ;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_READ: begin
        rd_en = 1'b1;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_END) state_d = S_DONE;
        else                      drain_d = drain_q + 1'b1;
      end
      S_DONE: begin
        pass_d  = (err_cnt_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      drain_q     <= 1'b0;
      mode_q      <= '0;
      seed_q      <= '0;
      inj_q       <= '0;
      inj_addr_q  <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      drain_q     <= drain_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      inj_q       <= inj_d;
      inj_addr_q  <= inj_addr_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign rd_valid       = cmp_vld;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: three builds (default, RD_LAT=2, DEPTH=32/ERR_W=4)
// driven from shared inputs and checked against a pattern-level model.
module tb_ram_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] seed;
  logic [1:0]  inj;
  logic [6:0]  inj_addr;

  logic        busy_a, done_a, pass_a, rv_a;
  logic [15:0] err_a, do_a;
  logic [6:0]  fea_a;
  logic        busy_b, done_b, pass_b, rv_b;
  logic [15:0] err_b, do_b;
  logic [6:0]  fea_b;
  logic        busy_c, done_c, pass_c, rv_c;
  logic [3:0]  err_c;
  logic [15:0] do_c;
  logic [4:0]  fea_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_bist_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
    .inj(inj), .inj_addr(inj_addr), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .first_err_addr(fea_a), .rd_valid(rv_a), .data_out(do_a)
  );

  ram_bist_ctrl #(.RD_LAT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
    .inj(inj), .inj_addr(inj_addr), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .first_err_addr(fea_b), .rd_valid(rv_b), .data_out(do_b)
  );

  ram_bist_ctrl #(.DEPTH(32), .ERR_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
    .inj(inj), .inj_addr(inj_addr[4:0]), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_cnt(err_c), .first_err_addr(fea_c), .rd_valid(rv_c), .data_out(do_c)
  );

  logic        busy_v [3];
  logic        done_v [3];
  logic        pass_v [3];
  logic        rv_v   [3];
  logic [15:0] err_v  [3];
  logic [6:0]  fea_v  [3];
  logic [15:0] do_v   [3];

  assign busy_v[0] = busy_a;  assign busy_v[1] = busy_b;  assign busy_v[2] = busy_c;
  assign done_v[0] = done_a;  assign done_v[1] = done_b;  assign done_v[2] = done_c;
  assign pass_v[0] = pass_a;  assign pass_v[1] = pass_b;  assign pass_v[2] = pass_c;
  assign rv_v[0]   = rv_a;    assign rv_v[1]   = rv_b;    assign rv_v[2]   = rv_c;
  assign err_v[0]  = err_a;   assign err_v[1]  = err_b;   assign err_v[2]  = {12'd0, err_c};
  assign fea_v[0]  = fea_a;   assign fea_v[1]  = fea_b;   assign fea_v[2]  = {2'd0, fea_c};
  assign do_v[0]   = do_a;    assign do_v[1]   = do_b;    assign do_v[2]   = do_c;

  function automatic int dep_of(input int i);
    return (i == 2) ? 32 : 100;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int emax_of(input int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  function automatic logic [15:0] exp_word(input logic [1:0] m, input logic [15:0] s, input int a);
    logic [15:0] a16;
    a16 = 16'(a);
    case (m)
      2'd0:    return s + a16;
      2'd1:    return s;
      2'd2:    return (a % 2 == 1) ? ~s : s;
      default: return s ^ a16;
    endcase
  endfunction

  function automatic logic [15:0] stored_word(input logic [1:0] m, input logic [15:0] s,
                                              input logic [1:0] ij, input int ia, input int a);
    logic f;
    f = (ij == 2'd2) || ((ij == 2'd1) && (a == ia));
    return exp_word(m, s, a) ^ {15'd0, f};
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    mode = 2'd0; seed = 16'd0; inj = 2'd0; inj_addr = 7'd0;
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || pass_v[i] !== 1'b0 || rv_v[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_ctrl dut%0d: busy=%b done=%b pass=%b rv=%b required all 0",
                 i, busy_v[i], done_v[i], pass_v[i], rv_v[i]);
      end
      checks++;
      if (err_v[i] !== 16'd0 || fea_v[i] !== 7'd0 || do_v[i] !== 16'd0) begin
        failures++;
        $display("FAIL reset_data dut%0d: err=%0d fea=%0d data=%h required 0",
                 i, err_v[i], fea_v[i], do_v[i]);
      end
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_patterns();
    logic [1:0]  tm [9];
    logic [15:0] ts [9];
    logic [1:0]  tj [9];
    logic [6:0]  ta [9];
    tm[0] = 2'd0; ts[0] = 16'h0001; tj[0] = 2'd0; ta[0] = 7'd0;
    tm[1] = 2'd0; ts[1] = 16'h0000; tj[1] = 2'd1; ta[1] = 7'd37;
    tm[2] = 2'd0; ts[2] = 16'hFFF0; tj[2] = 2'd0; ta[2] = 7'd0;
    tm[3] = 2'd2; ts[3] = 16'hA5A5; tj[3] = 2'd0; ta[3] = 7'd0;
    tm[4] = 2'd3; ts[4] = 16'hA5A5; tj[4] = 2'd0; ta[4] = 7'd0;
    tm[5] = 2'd1; ts[5] = 16'h0000; tj[5] = 2'd2; ta[5] = 7'd0;
    for (int n = 6; n < 9; n++) begin
      tm[n] = 2'($urandom_range(0, 3));
      ts[n] = 16'($urandom);
      tj[n] = 2'($urandom_range(0, 3));
      ta[n] = 7'($urandom_range(0, 127));
    end

    for (int n = 0; n < 9; n++) begin
      int ia [3];
      int ee [3];
      int ef [3];
      int rvn [3];
      bit fin [3];
      for (int i = 0; i < 3; i++) begin
        ia[i]  = (i == 2) ? int'(ta[n][4:0]) : int'(ta[n]);
        ee[i]  = 0;
        ef[i]  = 0;
        rvn[i] = 0;
        fin[i] = 1'b0;
        for (int a = 0; a < dep_of(i); a++) begin
          if (stored_word(tm[n], ts[n], tj[n], ia[i], a) != exp_word(tm[n], ts[n], a)) begin
            if (ee[i] == 0) ef[i] = a;
            ee[i]++;
          end
        end
        if (ee[i] > emax_of(i)) ee[i] = emax_of(i);
      end

      @(negedge clk);
      mode = tm[n]; seed = ts[n]; inj = tj[n]; inj_addr = ta[n];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      for (int k = 0; k < 206; k++) begin
        if (k == 60) start = 1'b1;
        if (k == 61) start = 1'b0;
        for (int i = 0; i < 3; i++) begin
          int dl;
          dl = 2 * dep_of(i) + lat_of(i);
          if (!fin[i]) begin
            if (k <= dl) begin
              checks++;
              if (busy_v[i] !== 1'b1) begin
                failures++;
                $display("FAIL busy run%0d dut%0d k=%0d: got %b required 1", n, i, k, busy_v[i]);
              end
            end
            if (rv_v[i] === 1'b1) begin
              checks++;
              if (rvn[i] >= dep_of(i) || k != dep_of(i) + lat_of(i) + rvn[i]) begin
                failures++;
                $display("FAIL rd_valid_time run%0d dut%0d: pulse %0d at k=%0d required k=%0d",
                         n, i, rvn[i], k, dep_of(i) + lat_of(i) + rvn[i]);
              end else begin
                checks++;
                if (do_v[i] !== stored_word(tm[n], ts[n], tj[n], ia[i], rvn[i])) begin
                  failures++;
                  $display("FAIL data_out run%0d dut%0d addr=%0d: got %h required %h", n, i, rvn[i],
                           do_v[i], stored_word(tm[n], ts[n], tj[n], ia[i], rvn[i]));
                end
              end
              rvn[i]++;
            end
            checks++;
            if (done_v[i] !== (k == dl)) begin
              failures++;
              $display("FAIL done run%0d dut%0d k=%0d: got %b required %b", n, i, k, done_v[i], (k == dl));
            end
            if (k == dl) begin
              checks++;
              if (rvn[i] != dep_of(i)) begin
                failures++;
                $display("FAIL rd_valid_count run%0d dut%0d: got %0d required %0d", n, i, rvn[i], dep_of(i));
              end
            end
            if (k == dl + 1) begin
              fin[i] = 1'b1;
              checks++;
              if (busy_v[i] !== 1'b0) begin
                failures++;
                $display("FAIL idle_busy run%0d dut%0d: got %b required 0", n, i, busy_v[i]);
              end
              checks++;
              if (pass_v[i] !== (ee[i] == 0)) begin
                failures++;
                $display("FAIL pass run%0d dut%0d: got %b required %b", n, i, pass_v[i], (ee[i] == 0));
              end
              checks++;
              if (err_v[i] !== 16'(ee[i])) begin
                failures++;
                $display("FAIL err_cnt run%0d dut%0d: got %0d required %0d", n, i, err_v[i], ee[i]);
              end
              checks++;
              if (fea_v[i] !== 7'(ef[i])) begin
                failures++;
                $display("FAIL first_err_addr run%0d dut%0d: got %0d required %0d", n, i, fea_v[i], ef[i]);
              end
            end
          end
        end
        @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (!fin[i]) begin
          failures++;
          $display("FAIL run_timeout run%0d dut%0d: run finished=0 required 1", n, i);
        end
      end
    end
  endtask

  task automatic test_abort();
    int dn;
    @(negedge clk);
    mode = 2'd0; seed = 16'h1234; inj = 2'd0; inj_addr = 7'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy_v[i] !== 1'b0) begin
        failures++;
        $display("FAIL abort_busy dut%0d: got %b required 0", i, busy_v[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 250; k++) begin
      for (int i = 0; i < 3; i++) if (done_v[i] === 1'b1 || busy_v[i] === 1'b1) dn++;
      @(negedge clk);
    end
    checks++;
    if (dn != 0) begin
      failures++;
      $display("FAIL abort_no_done: activity cycles=%0d required 0", dn);
    end
  endtask

  task automatic test_back_to_back();
    int ndone [3];
    @(negedge clk);
    mode = 2'd0; seed = 16'($urandom); inj = 2'd0; inj_addr = 7'd0;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) ndone[i] = 0;
    for (int k = 0; k < 420; k++) begin
      for (int i = 0; i < 3; i++) begin
        int dl;
        int per;
        bit exp_done;
        bit exp_idle;
        dl  = 2 * dep_of(i) + lat_of(i);
        per = dl + 2;
        exp_done = (k >= dl) && ((k - dl) % per == 0);
        exp_idle = (k >= dl + 1) && ((k - dl - 1) % per == 0);
        checks++;
        if (done_v[i] !== exp_done) begin
          failures++;
          $display("FAIL b2b_done dut%0d k=%0d: got %b required %b", i, k, done_v[i], exp_done);
        end
        checks++;
        if (busy_v[i] !== !exp_idle) begin
          failures++;
          $display("FAIL b2b_busy dut%0d k=%0d: got %b required %b", i, k, busy_v[i], !exp_idle);
        end
        if (exp_idle) begin
          checks++;
          if (pass_v[i] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pass dut%0d k=%0d: got %b required 1", i, k, pass_v[i]);
          end
        end
        if (done_v[i] === 1'b1) ndone[i]++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ndone[i] < 2) begin
        failures++;
        $display("FAIL b2b_runs dut%0d: got %0d required at least 2", i, ndone[i]);
      end
    end
    for (int k = 0; k < 220; k++) begin
      if (!busy_a && !busy_b && !busy_c) break;
      @(negedge clk);
    end
    checks++;
    if (busy_a || busy_b || busy_c) begin
      failures++;
      $display("FAIL b2b_settle: busy=%b%b%b required 000", busy_a, busy_b, busy_c);
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
